// File: rtl/swi_conditioner.sv
// Switch conditioner: per-bit 2-flop synchronizer, debounce counter, and
// registered one-cycle rise/fall pulses aligned with the new clean level.
module swi_conditioner #(
  parameter int unsigned NBITS_SW        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [NBITS_SW-1:0] SWI_raw,
  output logic [NBITS_SW-1:0] SWI_clean,
  output logic [NBITS_SW-1:0] SWI_rise,
  output logic [NBITS_SW-1:0] SWI_fall
);

  localparam int unsigned NBITS_DB = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NBITS_DB-1:0] CntLast = NBITS_DB'(DEBOUNCE_CYCLES - 1);
  localparam logic [NBITS_DB-1:0] CntOne  = NBITS_DB'(1);

  logic [NBITS_SW-1:0] r_sync1;
  logic [NBITS_SW-1:0] r_sync2;
  logic [NBITS_SW-1:0] r_clean;
  logic [NBITS_SW-1:0] r_rise;
  logic [NBITS_SW-1:0] r_fall;
  logic [NBITS_DB-1:0] r_cnt [NBITS_SW];

  logic [NBITS_SW-1:0] w_accept;
  logic [NBITS_DB-1:0] w_cnt_d [NBITS_SW];

  // Two-flop synchronizer; only r_sync2 feeds the debounce logic.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SWI_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce decision: count mismatches, accept on the last one,
  // and clear the count on any agreeing sample.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < int'(NBITS_SW); i++) begin
      w_cnt_d[i] = '0;
      if (r_sync2[i] != r_clean[i]) begin
        if (r_cnt[i] == CntLast) begin
          w_accept[i] = 1'b1;
        end else begin
          w_cnt_d[i] = r_cnt[i] + CntOne;
        end
      end
    end
  end

  // Debounce counters, clean level and edge pulses.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < int'(NBITS_SW); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // Accepting a bit flips it to r_sync2, so the pulse direction is r_sync2.
      r_clean <= (r_clean & ~w_accept) | (r_sync2 & w_accept);
      r_rise  <= w_accept & r_sync2;
      r_fall  <= w_accept & ~r_sync2;
      for (int i = 0; i < int'(NBITS_SW); i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign SWI_clean = r_clean;
  assign SWI_rise  = r_rise;
  assign SWI_fall  = r_fall;

endmodule

// File: tb/tb_swi_conditioner.sv
// Directed bench for swi_conditioner: default debounce (4) plus a
// DEBOUNCE_CYCLES=1 instance sharing clock and reset.
module tb_swi_conditioner;

  logic       clk_2;
  logic       reset;
  logic [7:0] raw_a;
  logic [7:0] clean_a;
  logic [7:0] rise_a;
  logic [7:0] fall_a;
  logic [7:0] raw_b;
  logic [7:0] clean_b;
  logic [7:0] rise_b;
  logic [7:0] fall_b;

  int n_checks;
  int n_pass;

  swi_conditioner #(
    .NBITS_SW       (8),
    .DEBOUNCE_CYCLES(4)
  ) u_dut_a (
    .clk_2    (clk_2),
    .reset    (reset),
    .SWI_raw  (raw_a),
    .SWI_clean(clean_a),
    .SWI_rise (rise_a),
    .SWI_fall (fall_a)
  );

  swi_conditioner #(
    .NBITS_SW       (8),
    .DEBOUNCE_CYCLES(1)
  ) u_dut_b (
    .clk_2    (clk_2),
    .reset    (reset),
    .SWI_raw  (raw_b),
    .SWI_clean(clean_b),
    .SWI_rise (rise_b),
    .SWI_fall (fall_b)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // 1: async reset with switches high, before any clock edge
    reset = 1'b1;
    raw_a = 8'hFF;
    raw_b = 8'h00;
    #1;
    check("rst_clean_a", clean_a, 8'h00);
    check("rst_rise_a", rise_a, 8'h00);
    check("rst_fall_a", fall_a, 8'h00);
    check("rst_clean_b", clean_b, 8'h00);
    tick(2);
    raw_a = 8'h00;
    reset = 1'b0;
    tick(8);
    check("rel_clean", clean_a, 8'h00);
    check("rel_rise", rise_a, 8'h00);

    // 2: single bit rise, exact latency
    raw_a = 8'h04;
    tick(5);
    check("t2_early_clean", clean_a, 8'h00);
    check("t2_early_rise", rise_a, 8'h00);
    tick(1);
    check("t2_clean", clean_a, 8'h04);
    check("t2_rise", rise_a, 8'h04);
    check("t2_fall", fall_a, 8'h00);
    tick(1);
    check("t2_rise_end", rise_a, 8'h00);
    check("t2_clean_hold", clean_a, 8'h04);

    // 3: glitch on bit 0 for 3 cycles is rejected
    raw_a = 8'h05;
    tick(3);
    raw_a = 8'h04;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_clean", clean_a, 8'h04);
      check("t3_pulse", rise_a | fall_a, 8'h00);
    end

    // Back to zero: fall pulse on bit 2
    raw_a = 8'h00;
    tick(5);
    check("t4_pre_clean", clean_a, 8'h04);
    tick(1);
    check("t4_pre_fall", fall_a, 8'h04);
    check("t4_pre_zero", clean_a, 8'h00);
    tick(2);

    // 4: multiple bits accepted together, then one falls
    raw_a = 8'hF0;
    tick(5);
    check("t4_early", clean_a, 8'h00);
    tick(1);
    check("t4_clean", clean_a, 8'hF0);
    check("t4_rise", rise_a, 8'hF0);
    check("t4_fall", fall_a, 8'h00);
    tick(1);
    check("t4_rise_end", rise_a, 8'h00);
    raw_a = 8'h70;
    tick(6);
    check("t4_clean70", clean_a, 8'h70);
    check("t4_fall80", fall_a, 8'h80);
    check("t4_rise0", rise_a, 8'h00);
    tick(1);
    check("t4_fall_end", fall_a, 8'h00);

    // 5: reset mid-count, then switch held through reset
    raw_a = 8'h72;
    tick(3);
    reset = 1'b1;
    #1;
    check("t5_rst_clean", clean_a, 8'h00);
    check("t5_rst_pulse", rise_a | fall_a, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("t5_early", clean_a, 8'h00);
    check("t5_early_rise", rise_a, 8'h00);
    tick(1);
    check("t5_clean", clean_a, 8'h72);
    check("t5_rise", rise_a, 8'h72);
    tick(1);
    check("t5_rise_end", rise_a, 8'h00);

    // 6: DEBOUNCE_CYCLES=1, three-edge latency
    raw_b = 8'h08;
    tick(2);
    check("t6_early", clean_b, 8'h00);
    tick(1);
    check("t6_clean", clean_b, 8'h08);
    check("t6_rise", rise_b, 8'h08);
    check("t6_fall", fall_b, 8'h00);
    tick(1);
    check("t6_rise_end", rise_b, 8'h00);
    check("t6_hold", clean_b, 8'h08);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
